// File: rtl/segment_capture_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment display path:
//   SEG_*      active-high segment patterns {a,b,c,d,e,f,g}; a is bit 6
//   AN_*       active-low anode selects, one per digit, plus the all-off value
//   frame_state_t  frame assembly state used by segment_capture
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    // COLLECTn means digit n is the next one expected in the scan
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT1 = 2'd1,
        ST_COLLECT2 = 2'd2,
        ST_COLLECT3 = 2'd3
    } frame_state_t;

endpackage

// File: rtl/segment_capture_if.sv
// -----------------------------------------------------------------------------
// segment_capture_if
// Captured-frame valid/ready channel.
//   digits       16  digits[4i+3:4i] = digit i
//   dots          4  dots[i] = digit i decimal point, active-high
//   frame_valid   1  frame available, held until accepted
//   frame_ready   1  consumer accepts on frame_valid && frame_ready
// master = frame producer (segment_capture), slave = consumer.
// -----------------------------------------------------------------------------
interface segment_capture_if;

    logic [15:0] digits;
    logic [3:0]  dots;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output digits,
        output dots,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  digits,
        input  dots,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/segment_capture_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational reverse lookup of an active-high segment pattern.
//   i_seg    7  pattern {a,b,c,d,e,f,g}, active-high
//   o_hit    1  pattern is one of the 14 known glyphs
//   o_value  4  decoded value (0 when o_hit is low)
// -----------------------------------------------------------------------------
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_value
);

    always_comb begin
        o_hit   = 1'b1;
        o_value = 4'h0;
        case (i_seg)
            SEG_0:   o_value = 4'h0;
            SEG_1:   o_value = 4'h1;
            SEG_2:   o_value = 4'h2;
            SEG_3:   o_value = 4'h3;
            SEG_4:   o_value = 4'h4;
            SEG_5:   o_value = 4'h5;
            SEG_6:   o_value = 4'h6;
            SEG_7:   o_value = 4'h7;
            SEG_8:   o_value = 4'h8;
            SEG_9:   o_value = 4'h9;
            SEG_A:   o_value = 4'hA;
            SEG_C:   o_value = 4'hC;
            SEG_E:   o_value = 4'hE;
            SEG_F:   o_value = 4'hF;
            default: o_hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/segment_capture.sv
// -----------------------------------------------------------------------------
// segment_capture
// Watches a multiplexed 4-digit 7-segment bus, samples each digit once its
// dwell has settled, decodes it and assembles complete 0,1,2,3 scans into
// frames on a valid/ready channel.
//   clk          system clock
//   rst          synchronous active-high reset
//   i_an     4   anodes, active-low (i_an[i] low selects digit i)
//   i_seg    7   cathodes {ca..cg}, active-low
//   i_dp     1   decimal point, active-low
//   frame_if     master side of segment_capture_if (digits/dots/valid/ready)
//   o_seg_err 1  pulse: undecodable pattern or several anodes low
//   o_overrun 1  pulse: new frame replaced an unaccepted one
// -----------------------------------------------------------------------------
module segment_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                i_an,
    input  logic [6:0]                i_seg,
    input  logic                      i_dp,
    segment_capture_if.master         frame_if,
    output logic                      o_seg_err,
    output logic                      o_overrun
);

    localparam logic [7:0] STROBE_AT = 8'(STABLE_CYCLES - 1);

    logic [3:0]   r_an;
    logic [6:0]   r_seg;
    logic         r_dp;
    logic [3:0]   r_anPrev;
    logic [6:0]   r_segPrev;
    logic         r_dpPrev;
    logic [7:0]   r_stableCnt;

    frame_state_t r_state;
    logic [11:0]  r_shadowDigits;
    logic [2:0]   r_shadowDots;
    logic [15:0]  r_digits;
    logic [3:0]   r_dots;
    logic         r_frameValid;
    logic         r_segErr;
    logic         r_overrun;

    logic         w_change;
    logic         w_strobe;
    logic [1:0]   w_anIdx;
    logic         w_anOne;
    logic         w_anNone;
    logic         w_anMulti;
    logic [6:0]   w_segHigh;
    logic         w_hit;
    logic [3:0]   w_value;

    // Input registers reset to the idle bus (everything off) so that a
    // stable idle bus after reset never looks like a multi-anode error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an        <= AN_NONE;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_anPrev    <= AN_NONE;
            r_segPrev   <= 7'h7F;
            r_dpPrev    <= 1'b1;
            r_stableCnt <= 8'd0;
        end else begin
            r_an      <= i_an;
            r_seg     <= i_seg;
            r_dp      <= i_dp;
            r_anPrev  <= r_an;
            r_segPrev <= r_seg;
            r_dpPrev  <= r_dp;
            if (w_change) begin
                r_stableCnt <= 8'd0;
            end else if (r_stableCnt != 8'hFF) begin
                r_stableCnt <= r_stableCnt + 8'd1;
            end
        end
    end

    assign w_change = ({r_an, r_seg, r_dp} != {r_anPrev, r_segPrev, r_dpPrev});

    // The counter passes STROBE_AT only once per dwell, so this fires once.
    assign w_strobe = !w_change && (r_stableCnt == STROBE_AT);

    always_comb begin
        w_anIdx  = 2'd0;
        w_anOne  = 1'b0;
        w_anNone = 1'b0;
        case (r_an)
            AN_DIG0: begin w_anOne = 1'b1; w_anIdx = 2'd0; end
            AN_DIG1: begin w_anOne = 1'b1; w_anIdx = 2'd1; end
            AN_DIG2: begin w_anOne = 1'b1; w_anIdx = 2'd2; end
            AN_DIG3: begin w_anOne = 1'b1; w_anIdx = 2'd3; end
            AN_NONE: w_anNone = 1'b1;
            default: ;
        endcase
    end

    assign w_anMulti = !w_anOne && !w_anNone;
    assign w_segHigh = ~r_seg;

    seg7_decode u_decode (
        .i_seg   (w_segHigh),
        .o_hit   (w_hit),
        .o_value (w_value)
    );

    // Frame assembly. Digit 0 always (re)starts a frame; an out-of-order
    // digit silently drops the partial frame. Digit 3 commits straight into
    // the output registers, so the frame appears one clock after its strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_shadowDigits <= 12'd0;
            r_shadowDots   <= 3'd0;
            r_digits       <= 16'd0;
            r_dots         <= 4'd0;
            r_frameValid   <= 1'b0;
            r_segErr       <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_segErr  <= 1'b0;
            r_overrun <= 1'b0;
            if (r_frameValid && frame_if.frame_ready) begin
                r_frameValid <= 1'b0;
            end
            if (w_strobe && !w_anNone) begin
                if (w_anMulti || !w_hit) begin
                    r_segErr <= 1'b1;
                    r_state  <= ST_IDLE;
                end else if (w_anIdx == 2'd0) begin
                    r_shadowDigits[3:0] <= w_value;
                    r_shadowDots[0]     <= ~r_dp;
                    r_state             <= ST_COLLECT1;
                end else begin
                    case (r_state)
                        ST_COLLECT1: begin
                            if (w_anIdx == 2'd1) begin
                                r_shadowDigits[7:4] <= w_value;
                                r_shadowDots[1]     <= ~r_dp;
                                r_state             <= ST_COLLECT2;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_COLLECT2: begin
                            if (w_anIdx == 2'd2) begin
                                r_shadowDigits[11:8] <= w_value;
                                r_shadowDots[2]      <= ~r_dp;
                                r_state              <= ST_COLLECT3;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_COLLECT3: begin
                            if (w_anIdx == 2'd3) begin
                                r_digits     <= {w_value, r_shadowDigits};
                                r_dots       <= {~r_dp, r_shadowDots};
                                r_frameValid <= 1'b1;
                                if (r_frameValid && !frame_if.frame_ready) begin
                                    r_overrun <= 1'b1;
                                end
                            end
                            r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign frame_if.digits      = r_digits;
    assign frame_if.dots        = r_dots;
    assign frame_if.frame_valid = r_frameValid;
    assign o_seg_err            = r_segErr;
    assign o_overrun            = r_overrun;

endmodule

// File: tb/tb_segment_capture.sv
// -----------------------------------------------------------------------------
// tb_segment_capture
// Directed bench for segment_capture: emulates the scanning display driver,
// counts seg_err/overrun pulses and accepted frames, and checks against
// hand-computed frames.
// -----------------------------------------------------------------------------
module tb_segment_capture;

    localparam int DWELL = 8;

    logic       clk;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       segErr;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    int acceptCount = 0;
    int errCount    = 0;
    int ovrCount    = 0;

    segment_capture_if scIf ();

    segment_capture #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_an      (an),
        .i_seg     (seg),
        .i_dp      (dp),
        .frame_if  (scIf.master),
        .o_seg_err (segErr),
        .o_overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and handshake monitor, sampled on the active edge
    always @(posedge clk) begin
        if (!rst) begin
            if (scIf.frame_valid && scIf.frame_ready) acceptCount <= acceptCount + 1;
            if (segErr)  errCount <= errCount + 1;
            if (overrun) ovrCount <= ovrCount + 1;
        end
    end

    // Bench-side glyph table, active-high {a..g}
    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b1111110;
            4'h1: enc = 7'b0110000;
            4'h2: enc = 7'b1101101;
            4'h3: enc = 7'b1111001;
            4'h4: enc = 7'b0110011;
            4'h5: enc = 7'b1011011;
            4'h6: enc = 7'b1011111;
            4'h7: enc = 7'b1110000;
            4'h8: enc = 7'b1111111;
            4'h9: enc = 7'b1111011;
            4'hA: enc = 7'b1110111;
            4'hC: enc = 7'b1001110;
            4'hE: enc = 7'b1001111;
            4'hF: enc = 7'b1000111;
            default: enc = 7'b0000000;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] anV, input logic [6:0] segV,
                                 input logic dpV, input int cycles);
        an  = anV;
        seg = segV;
        dp  = dpV;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleBus(input int cycles);
        applyStimulus(4'hF, 7'h7F, 1'b1, cycles);
    endtask

    task automatic driveDigit(input int idx, input logic [3:0] v, input logic dot);
        logic [3:0] anV;
        anV = 4'hF;
        anV[idx] = 1'b0;
        applyStimulus(anV, ~enc(v), ~dot, DWELL);
    endtask

    task automatic scanFrame(input logic [15:0] vals, input logic [3:0] dots);
        for (int i = 0; i < 4; i++) begin
            driveDigit(i, vals[4*i +: 4], dots[i]);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int accBase;
        int errBase;
        int ovrBase;

        rst = 1'b1;
        scIf.frame_ready = 1'b0;
        an  = 4'hF;
        seg = 7'h7F;
        dp  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_digits", 32'(scIf.digits), 32'h0);
        checkOutput("reset_dots", 32'(scIf.dots), 32'h0);
        checkOutput("reset_valid", 32'(scIf.frame_valid), 32'h0);
        checkOutput("reset_segerr", 32'(segErr), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        idleBus(4);

        // Loopback 1,2,3,4 with dot on digit 1, consumer always ready
        $display("[TB] loopback 4321, ready high");
        scIf.frame_ready = 1'b1;
        accBase = acceptCount;
        errBase = errCount;
        scanFrame(16'h4321, 4'b0010);
        scanFrame(16'h4321, 4'b0010);
        idleBus(4);
        checkOutput("lb1_accepts", 32'(acceptCount - accBase), 32'd2);
        checkOutput("lb1_digits", 32'(scIf.digits), 32'h4321);
        checkOutput("lb1_dots", 32'(scIf.dots), 32'b0010);
        checkOutput("lb1_segerr", 32'(errCount - errBase), 32'd0);
        checkOutput("lb1_valid_idle", 32'(scIf.frame_valid), 32'h0);

        // Loopback F,E,C,A with consumer stalled, then overrun
        $display("[TB] loopback FECA, ready low");
        scIf.frame_ready = 1'b0;
        ovrBase = ovrCount;
        scanFrame(16'hFECA, 4'b0000);
        idleBus(4);
        checkOutput("lb2_valid1", 32'(scIf.frame_valid), 32'h1);
        checkOutput("lb2_digits1", 32'(scIf.digits), 32'hFECA);
        checkOutput("lb2_overrun1", 32'(ovrCount - ovrBase), 32'd0);
        scanFrame(16'hFECA, 4'b0000);
        idleBus(4);
        checkOutput("lb2_overrun2", 32'(ovrCount - ovrBase), 32'd1);
        checkOutput("lb2_digits2", 32'(scIf.digits), 32'hFECA);
        checkOutput("lb2_valid2", 32'(scIf.frame_valid), 32'h1);
        scIf.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        scIf.frame_ready = 1'b0;
        checkOutput("lb2_valid_cleared", 32'(scIf.frame_valid), 32'h0);
        idleBus(2);
        checkOutput("lb2_valid_stays", 32'(scIf.frame_valid), 32'h0);

        // Glitch: digit 0 held too briefly must not start a frame
        $display("[TB] glitch on digit 0");
        scIf.frame_ready = 1'b1;
        accBase = acceptCount;
        errBase = errCount;
        applyStimulus(4'b1110, ~enc(4'h5), 1'b1, 2);
        idleBus(10);
        driveDigit(1, 4'h5, 1'b0);
        driveDigit(2, 4'h5, 1'b0);
        driveDigit(3, 4'h5, 1'b0);
        idleBus(4);
        checkOutput("glitch_accepts", 32'(acceptCount - accBase), 32'd0);
        checkOutput("glitch_segerr", 32'(errCount - errBase), 32'd0);
        checkOutput("glitch_valid", 32'(scIf.frame_valid), 32'h0);
        checkOutput("glitch_digits", 32'(scIf.digits), 32'hFECA);

        // Undecodable pattern (only segment g lit)
        $display("[TB] undecodable pattern");
        errBase = errCount;
        accBase = acceptCount;
        applyStimulus(4'b1110, ~7'b0000001, 1'b1, 10);
        idleBus(4);
        checkOutput("bad_seg_err", 32'(errCount - errBase), 32'd1);
        checkOutput("bad_seg_accepts", 32'(acceptCount - accBase), 32'd0);
        checkOutput("bad_seg_valid", 32'(scIf.frame_valid), 32'h0);

        // Two anodes low, then a clean 7777 frame
        $display("[TB] two anodes low, then clean frame");
        errBase = errCount;
        accBase = acceptCount;
        applyStimulus(4'b1100, ~enc(4'h7), 1'b1, 10);
        idleBus(4);
        checkOutput("multi_an_err", 32'(errCount - errBase), 32'd1);
        scanFrame(16'h7777, 4'b0000);
        idleBus(4);
        checkOutput("clean_accepts", 32'(acceptCount - accBase), 32'd1);
        checkOutput("clean_digits", 32'(scIf.digits), 32'h7777);
        checkOutput("clean_dots", 32'(scIf.dots), 32'h0);
        checkOutput("clean_err_total", 32'(errCount - errBase), 32'd1);

        // Reset in the middle of a frame discards it
        $display("[TB] reset mid-frame");
        accBase = acceptCount;
        driveDigit(0, 4'h9, 1'b1);
        driveDigit(1, 4'h8, 1'b0);
        rst = 1'b1;
        applyStimulus(4'hF, 7'h7F, 1'b1, 1);
        rst = 1'b0;
        checkOutput("rst_mid_digits", 32'(scIf.digits), 32'h0);
        driveDigit(2, 4'h6, 1'b0);
        driveDigit(3, 4'h5, 1'b1);
        idleBus(4);
        checkOutput("rst_mid_accepts", 32'(acceptCount - accBase), 32'd0);
        checkOutput("rst_mid_valid", 32'(scIf.frame_valid), 32'h0);
        scanFrame(16'h5689, 4'b1001);
        idleBus(4);
        checkOutput("post_rst_accepts", 32'(acceptCount - accBase), 32'd1);
        checkOutput("post_rst_digits", 32'(scIf.digits), 32'h5689);
        checkOutput("post_rst_dots", 32'(scIf.dots), 32'b1001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
